decode_67b_block_sync: RTL and testbench

// - Parametrised next-generation Interlaken 64B/67B receive decoder: word aligner, block-sync FSM,
//   bit-66 inversion removal. Sits between the SerDes gearbox (DATA_W+3-bit words) and the lane deskew/descrambler.
// - Adds over the previous decoder:
//   - configurable lock/unlock thresholds and error window
//   - post-slip settle delay
//   - per-word header-error flag
//   - qualified output valid
//   - optional statistics counters

---
 rtl/decode_67b_block_sync.sv | 213 +++++++++++++++++++++
 tb/tb_decode_67b_block_sync.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_67b_block_sync.sv
// decode_67b_block_sync
// Interlaken 64B/67B receive decoder: word aligner, block-sync FSM and
// bit-66 inversion removal between the SerDes gearbox and lane deskew.
//
// Optional feature macro: DEC67_STATS_EN adds STATS_CLR and saturating
// SLIP_COUNT / HDR_ERR_COUNT / LOCK_LOSS_COUNT statistics outputs.
//
// Ports
//   USER_CLK        clock, rising edge
//   SYSTEM_RESET_N  asynchronous active-low reset
//   PASSTHROUGH     bypass alignment: offset 0, FSM held in SYNCING
//   DATA_IN         gearbox word (W = DATA_W+3), bit W-1 received first
//   DATA_IN_VALID   DATA_IN qualifier
//   DATA_OUT        payload with inversion removed
//   HEADER_OUT      aligned sync header
//   CTRL_OUT        header is 2'b10
//   HDR_ERR         header is 2'b00 or 2'b11
//   DATA_OUT_VALID  output word valid (locked or passthrough)
//   LOCKED          FSM in LOCKED
//   CANDIDATE       current bit offset 0..W-1
module decode_67b_block_sync #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned GOOD_LOCK_CNT  = 64,
  parameter int unsigned ERR_WINDOW     = 64,
  parameter int unsigned BAD_UNLOCK_CNT = 16,
  parameter int unsigned SLIP_SETTLE    = 2
) (
  input  logic                           USER_CLK,
  input  logic                           SYSTEM_RESET_N,
  input  logic                           PASSTHROUGH,
`ifdef DEC67_STATS_EN
  input  logic                           STATS_CLR,
  output logic [15:0]                    SLIP_COUNT,
  output logic [15:0]                    HDR_ERR_COUNT,
  output logic [7:0]                     LOCK_LOSS_COUNT,
`endif
  input  logic [DATA_W+2:0]              DATA_IN,
  input  logic                           DATA_IN_VALID,
  output logic [DATA_W-1:0]              DATA_OUT,
  output logic [1:0]                     HEADER_OUT,
  output logic                           CTRL_OUT,
  output logic                           HDR_ERR,
  output logic                           DATA_OUT_VALID,
  output logic                           LOCKED,
  output logic [$clog2(DATA_W+3)-1:0]    CANDIDATE
);

  localparam int unsigned W        = DATA_W + 3;
  localparam int unsigned CAND_W   = $clog2(W);
  localparam int unsigned GC_W     = $clog2(GOOD_LOCK_CNT);
  localparam int unsigned WC_W     = $clog2(ERR_WINDOW);
  localparam int unsigned BC_W     = $clog2(BAD_UNLOCK_CNT + 1);
  localparam int unsigned SETTLE_W = (SLIP_SETTLE > 0) ? $clog2(SLIP_SETTLE + 1) : 1;

  typedef enum logic {ST_SYNCING = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [GC_W-1:0]     good_q, good_d;
  logic [WC_W-1:0]     win_cnt_q, win_cnt_d;
  logic [BC_W-1:0]     bad_q, bad_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CAND_W-1:0]   cand_q, cand_d;

  logic [W-1:0]        prev_q;
  logic [2*W-1:0]      win_q;
  logic                win_v_q;
  logic [CAND_W-1:0]   cand_eff_c;
  logic [2*W-1:0]      shifted_c;
  logic [W-1:0]        aligned_c;
  logic                good_c;

  // Two-word window; only valid gearbox words advance it
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      prev_q  <= '0;
      win_q   <= '0;
      win_v_q <= 1'b0;
    end else begin
      win_v_q <= DATA_IN_VALID;
      if (DATA_IN_VALID) begin
        prev_q <= DATA_IN;
        win_q  <= {prev_q, DATA_IN};
      end
    end
  end

  // Passthrough overrides the offset immediately, before the register clears
  assign cand_eff_c = PASSTHROUGH ? '0 : cand_q;
  assign shifted_c  = win_q >> cand_eff_c;
  assign aligned_c  = shifted_c[W-1:0];
  assign good_c     = aligned_c[W-2] ^ aligned_c[W-3];

  // FSM and counter registers
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state_q   <= ST_SYNCING;
      good_q    <= '0;
      win_cnt_q <= '0;
      bad_q     <= '0;
      settle_q  <= '0;
      cand_q    <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      win_cnt_q <= win_cnt_d;
      bad_q     <= bad_d;
      settle_q  <= settle_d;
      cand_q    <= cand_d;
    end
  end

  // Next-state: acquisition slips the offset, LOCKED tracks errors per window
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    win_cnt_d = win_cnt_q;
    bad_d     = bad_q;
    settle_d  = settle_q;
    cand_d    = cand_q;
    if (PASSTHROUGH) begin
      state_d   = ST_SYNCING;
      good_d    = '0;
      win_cnt_d = '0;
      bad_d     = '0;
      settle_d  = '0;
      cand_d    = '0;
    end else if (win_v_q) begin
      unique case (state_q)
        ST_SYNCING: begin
          if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
          end else if (good_c) begin
            if (good_q == GC_W'(GOOD_LOCK_CNT - 1)) begin
              state_d   = ST_LOCKED;
              good_d    = '0;
              win_cnt_d = '0;
              bad_d     = '0;
            end else begin
              good_d = good_q + GC_W'(1);
            end
          end else begin
            good_d   = '0;
            cand_d   = (cand_q == CAND_W'(W - 1)) ? '0 : cand_q + CAND_W'(1);
            settle_d = SETTLE_W'(SLIP_SETTLE);
          end
        end
        ST_LOCKED: begin
          // Unlock takes priority over a window restart on the same word
          if (!good_c && (bad_q == BC_W'(BAD_UNLOCK_CNT - 1))) begin
            state_d   = ST_SYNCING;
            good_d    = '0;
            win_cnt_d = '0;
            bad_d     = '0;
            settle_d  = '0;
          end else if (win_cnt_q == WC_W'(ERR_WINDOW - 1)) begin
            win_cnt_d = '0;
            bad_d     = '0;
          end else begin
            win_cnt_d = win_cnt_q + WC_W'(1);
            if (!good_c) bad_d = bad_q + BC_W'(1);
          end
        end
        default: state_d = ST_SYNCING;
      endcase
    end
  end

  // Output register: header decode and inversion removal every clock
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      DATA_OUT       <= '0;
      HEADER_OUT     <= '0;
      CTRL_OUT       <= 1'b0;
      HDR_ERR        <= 1'b0;
      DATA_OUT_VALID <= 1'b0;
    end else begin
      DATA_OUT       <= aligned_c[W-1] ? ~aligned_c[DATA_W-1:0] : aligned_c[DATA_W-1:0];
      HEADER_OUT     <= aligned_c[W-2:W-3];
      CTRL_OUT       <= (aligned_c[W-2:W-3] == 2'b10);
      HDR_ERR        <= ~good_c;
      DATA_OUT_VALID <= win_v_q & ((state_q == ST_LOCKED) | PASSTHROUGH);
    end
  end

  assign LOCKED    = (state_q == ST_LOCKED);
  assign CANDIDATE = cand_q;

`ifdef DEC67_STATS_EN
  logic slip_ev_c, hdr_err_ev_c, lock_loss_ev_c;

  assign slip_ev_c      = !PASSTHROUGH && (cand_d != cand_q);
  assign hdr_err_ev_c   = !PASSTHROUGH && win_v_q && (state_q == ST_LOCKED) && !good_c;
  assign lock_loss_ev_c = (state_q == ST_LOCKED) && (state_d == ST_SYNCING);

  // Saturating statistics; clear beats increment
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      SLIP_COUNT      <= '0;
      HDR_ERR_COUNT   <= '0;
      LOCK_LOSS_COUNT <= '0;
    end else if (STATS_CLR) begin
      SLIP_COUNT      <= '0;
      HDR_ERR_COUNT   <= '0;
      LOCK_LOSS_COUNT <= '0;
    end else begin
      if (slip_ev_c && (SLIP_COUNT != '1))           SLIP_COUNT      <= SLIP_COUNT + 16'd1;
      if (hdr_err_ev_c && (HDR_ERR_COUNT != '1))     HDR_ERR_COUNT   <= HDR_ERR_COUNT + 16'd1;
      if (lock_loss_ev_c && (LOCK_LOSS_COUNT != '1)) LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_67b_block_sync.sv
// Bench for decode_67b_block_sync (default parameters, statistics disabled).
module tb_decode_67b_block_sync;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  h;
    logic        c;
    logic        e;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pt;
  logic [66:0] din;
  logic        din_v;
  logic [63:0] dout;
  logic [1:0]  hdr;
  logic        ctrl;
  logic        herr;
  logic        dout_v;
  logic        locked;
  logic [6:0]  cand;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  decode_67b_block_sync dut (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .PASSTHROUGH    (pt),
    .DATA_IN        (din),
    .DATA_IN_VALID  (din_v),
    .DATA_OUT       (dout),
    .HEADER_OUT     (hdr),
    .CTRL_OUT       (ctrl),
    .HDR_ERR        (herr),
    .DATA_OUT_VALID (dout_v),
    .LOCKED         (locked),
    .CANDIDATE      (cand)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, dout, 64'd0);
    chk({tag, "_hdr"}, 64'(hdr), 64'd0);
    chk({tag, "_ctrl"}, 64'(ctrl), 64'd0);
    chk({tag, "_herr"}, 64'(herr), 64'd0);
    chk({tag, "_valid"}, 64'(dout_v), 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_cand"}, 64'(cand), 64'd0);
  endtask

  // Expected output for a correctly aligned block {inv, header, raw payload}
  function automatic exp_t exp_of(input logic [66:0] b);
    exp_t e;
    e.d = b[66] ? ~b[63:0] : b[63:0];
    e.h = b[65:64];
    e.c = (b[65:64] == 2'b10);
    e.e = (b[65] == b[64]);
    return e;
  endfunction

  // Offset-0 stream: alternating 01/10, 15 bad headers in window 64..127,
  // 16 bad headers from word 128 (16th at word 158), inversion vector at 101
  function automatic logic [66:0] blk_b(input int j);
    logic [1:0]  h;
    logic [63:0] raw;
    h = j[0] ? 2'b10 : 2'b01;
    if (j >= 64 && j <= 120 && ((j - 64) % 4) == 0) h = (j % 8 == 0) ? 2'b00 : 2'b11;
    if (j >= 128 && j <= 158 && (j % 2) == 0)       h = (j % 4 == 0) ? 2'b11 : 2'b00;
    raw = {16'hC0DE, 16'(j), ~16'(j), 16'h5A5A};
    if (j == 101) return {1'b1, 2'b01, 64'hFFFF_0000_FFFF_0000};
    return {j[1], h, raw};
  endfunction

  // Blocks whose stream positions 2..39 are constant, so every offset
  // reached before the true one (37) sees a bad header
  function automatic logic [66:0] blk_c(input int j);
    logic [1:0]  h;
    logic [63:0] raw;
    h = j[0] ? 2'b10 : 2'b01;
    raw[63:27] = {37{h[0]}};
    raw[26:0]  = 27'(j * 1237 + 99);
    return {j[1], h, raw};
  endfunction

  // Gearbox word j starts 37 bits into block j
  function automatic logic [66:0] word_c(input int j);
    logic [66:0] a;
    logic [66:0] b;
    a = blk_c(j);
    b = blk_c(j + 1);
    return {a[29:0], b[66:30]};
  endfunction

  task automatic drive(input logic [66:0] w, input logic v);
    @(posedge clk);
    #1;
    din   = w;
    din_v = v;
  endtask

  task automatic do_reset();
    din_v = 1'b0;
    pt    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every valid output word must match the next expected entry
  initial begin
    exp_t got, want;
    forever begin
      @(negedge clk);
      if (dout_v === 1'b1) begin
        got = '{d: dout, h: hdr, c: ctrl, e: herr};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got d=%h h=%b expected no output", dout, hdr);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL out_word: got d=%h h=%b c=%b e=%b expected d=%h h=%b c=%b e=%b",
                     got.d, got.h, got.c, got.e, want.d, want.h, want.c, want.e);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no end of run expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [66:0] pw [6];
    logic        pv [6];
    exp_t        pe [6];

    din   = '0;
    din_v = 1'b0;
    pt    = 1'b0;
    rst_n = 1'b0;
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Offset 0: lock on 64th word, tolerate 15 errors, unlock on 16th
    for (int j = 0; j < 192; j++) begin
      drive(blk_b(j), 1'b1);
      if (j == 101)
        exp_q.push_back('{d: 64'h0000_FFFF_0000_FFFF, h: 2'b01, c: 1'b0, e: 1'b0});
      else if (j >= 64 && j <= 158)
        exp_q.push_back(exp_of(blk_b(j)));
      if (j == 64) chk("b_not_locked_63", 64'(locked), 64'd0);
      if (j == 65) begin
        chk("b_locked_64", 64'(locked), 64'd1);
        chk("b_cand", 64'(cand), 64'd0);
      end
      if (j == 159) chk("b_locked_15_errs", 64'(locked), 64'd1);
      if (j == 160) begin
        chk("b_unlock_16th", 64'(locked), 64'd0);
        chk("b_cand_kept", 64'(cand), 64'd0);
      end
    end
    repeat (4) drive('0, 1'b0);

    // Offset 37 with settle 2: slips 0..37, then 64 good words
    do_reset();
    for (int j = 0; j < 200; j++) begin
      drive(word_c(j), 1'b1);
      if (j >= 175) exp_q.push_back(exp_of(blk_c(j)));
      if (j == 62) chk("c_cand_mid", 64'(cand), 64'd21);
      if (j == 113) begin
        chk("c_cand_37", 64'(cand), 64'd37);
        chk("c_not_locked", 64'(locked), 64'd0);
      end
      if (j == 175) chk("c_not_locked_63", 64'(locked), 64'd0);
      if (j == 176) begin
        chk("c_locked", 64'(locked), 64'd1);
        chk("c_cand_final", 64'(cand), 64'd37);
      end
    end
    repeat (4) drive('0, 1'b0);
    chk("d_pre_pt_locked", 64'(locked), 64'd1);

    // Passthrough while locked
    pw[0] = {1'b1, 2'b01, 64'hFFFF_0000_FFFF_0000}; pv[0] = 1'b1;
    pe[0] = '{d: 64'h0000_FFFF_0000_FFFF, h: 2'b01, c: 1'b0, e: 1'b0};
    pw[1] = {1'b0, 2'b11, 64'hDEAD_BEEF_DEAD_BEEF}; pv[1] = 1'b0; pe[1] = '0;
    pw[2] = {1'b0, 2'b10, 64'h0123_4567_89AB_CDEF}; pv[2] = 1'b1;
    pe[2] = '{d: 64'h0123_4567_89AB_CDEF, h: 2'b10, c: 1'b1, e: 1'b0};
    pw[3] = {1'b1, 2'b11, 64'h0};                   pv[3] = 1'b1;
    pe[3] = '{d: 64'hFFFF_FFFF_FFFF_FFFF, h: 2'b11, c: 1'b0, e: 1'b1};
    pw[4] = {1'b1, 2'b00, 64'h1111_2222_3333_4444}; pv[4] = 1'b0; pe[4] = '0;
    pw[5] = {1'b0, 2'b00, 64'h8000_0000_0000_0001}; pv[5] = 1'b1;
    pe[5] = '{d: 64'h8000_0000_0000_0001, h: 2'b00, c: 1'b0, e: 1'b1};
    @(posedge clk);
    #1 pt = 1'b1;
    repeat (2) drive('0, 1'b0);
    chk("d_pt_locked", 64'(locked), 64'd0);
    chk("d_pt_cand", 64'(cand), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive(pw[i], pv[i]);
      if (pv[i]) exp_q.push_back(pe[i]);
    end
    repeat (3) drive('0, 1'b0);
    @(posedge clk);
    #1 pt = 1'b0;
    repeat (3) drive('0, 1'b0);
    chk("d_post_pt_locked", 64'(locked), 64'd0);
    chk("d_post_pt_cand", 64'(cand), 64'd0);

    // All-bad stream: candidate wraps W-1 -> 0
    do_reset();
    for (int j = 0; j < 201; j++) begin
      drive('0, 1'b1);
      if (j == 197) chk("e_cand_66", 64'(cand), 64'd66);
      if (j == 199) chk("e_cand_hold", 64'(cand), 64'd66);
      if (j == 200) chk("e_cand_wrap", 64'(cand), 64'd0);
    end
    repeat (3) drive('0, 1'b0);

    // Valid 1-in-3 during acquisition, then async reset while locked
    do_reset();
    for (int j = 0; j < 70; j++) begin
      drive(blk_b(j), 1'b1);
      if (j >= 64) exp_q.push_back(exp_of(blk_b(j)));
      drive('0, 1'b0);
      drive('0, 1'b0);
      if (j == 62) chk("f_not_locked_63", 64'(locked), 64'd0);
      if (j == 63) chk("f_locked_64", 64'(locked), 64'd1);
    end
    repeat (4) drive('0, 1'b0);
    chk("f_pre_reset_locked", 64'(locked), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
